// File: rtl/fa.sv
// One-bit full adder shared by the bit-serial adder datapath.
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ ci;
    assign carry = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full adder, LSB first, one bit per clock,
// registered sum/carry-out with a one-cycle done pulse.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic             cflop;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_carry;

    fa u_fa (
        .a     (opa[0]),
        .b     (opb[0]),
        .ci    (cflop),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Accumulator fills from the MSB so the last bit lands with the LSB at bit 0.
    if (WIDTH == 1) begin : g_acc_w1
        assign acc_nxt = fa_sum;
    end else begin : g_acc_wn
        assign acc_nxt = {fa_sum, acc[WIDTH-1:1]};
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            cflop <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            carry <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        cflop <= ci;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    acc   <= acc_nxt;
                    cflop <= fa_carry;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum   <= acc_nxt;
                        carry <= fa_carry;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for the bit-serial adder: 8-bit and 1-bit instances.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start8, ci8, busy8, done8, carry8;
    logic [7:0] a8, b8, sum8;
    logic       start1, a1, b1, ci1, busy1, done1, sum1, carry1;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .ci(ci8),
        .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .ci(ci1),
        .busy(busy1), .done(done1), .sum(sum1), .carry(carry1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       c;
    } vec_t;

    int         nchk = 0;
    int         nerr = 0;
    logic [7:0] prev_s = 8'h00;
    logic       prev_c = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Accept one 8-bit add, then track busy/done timing and the result.
    task automatic add8(input logic [7:0] ia, input logic [7:0] ib, input logic ici,
                        input logic [7:0] es, input logic ec, input string nm);
        int busy_n = 0;
        int lat    = 0;
        bit seen   = 0;
        a8 = ia; b8 = ib; ci8 = ici; start8 = 1'b1;
        step();
        start8 = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (done8) begin
                seen = 1;
            end else begin
                chk({nm, " sum hold"}, 32'(sum8), 32'(prev_s));
                if (busy8) busy_n++;
                step();
                lat++;
            end
        end
        if (!seen) begin
            chk({nm, " done timeout"}, 32'(0), 32'(1));
        end else begin
            chk({nm, " latency"}, 32'(lat), 32'(8));
            chk({nm, " busy cycles"}, 32'(busy_n), 32'(8));
            chk({nm, " busy at done"}, 32'(busy8), 32'(0));
            chk({nm, " sum"}, 32'(sum8), 32'(es));
            chk({nm, " carry"}, 32'(carry8), 32'(ec));
            step();
            chk({nm, " done width"}, 32'(done8), 32'(0));
            chk({nm, " idle busy"}, 32'(busy8), 32'(0));
        end
        prev_s = es;
        prev_c = ec;
    endtask

    initial begin
        vec_t       tv[6];
        vec_t       bb[4];
        logic [1:0] exp1[8];
        logic [2:0] combo;
        int         dones;
        time        t_prev;

        tv[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tv[1] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        tv[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        tv[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        tv[4] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
        tv[5] = '{8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0};

        bb[0] = '{8'h11, 8'h22, 1'b0, 8'h33, 1'b0};
        bb[1] = '{8'hF0, 8'h20, 1'b0, 8'h10, 1'b1};
        bb[2] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
        bb[3] = '{8'h55, 8'h55, 1'b1, 8'hAB, 1'b0};

        exp1[0] = 2'b00; exp1[1] = 2'b01; exp1[2] = 2'b01; exp1[3] = 2'b10;
        exp1[4] = 2'b01; exp1[5] = 2'b10; exp1[6] = 2'b10; exp1[7] = 2'b11;

        // Reset held with start asserted.
        rst_n = 1'b0;
        start8 = 1'b1; a8 = tv[0].a; b8 = tv[0].b; ci8 = tv[0].ci;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
        repeat (3) begin
            step();
            chk("reset busy", 32'(busy8), 32'(0));
            chk("reset done", 32'(done8), 32'(0));
        end
        chk("reset sum", 32'(sum8), 32'(8'h00));
        chk("reset carry", 32'(carry8), 32'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            add8(tv[i].a, tv[i].b, tv[i].ci, tv[i].s, tv[i].c, $sformatf("vec%0d", i));

        // Start pulsed mid-run with different operands must be ignored.
        a8 = 8'h01; b8 = 8'h01; ci8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        dones = 0;
        step(); step();
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        step();
        start8 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (done8) begin
                dones++;
                chk("ign sum", 32'(sum8), 32'(8'h02));
                chk("ign carry", 32'(carry8), 32'(0));
            end else if (dones == 0) begin
                chk("ign sum hold", 32'(sum8), 32'(prev_s));
            end
            step();
        end
        chk("ign done count", 32'(dones), 32'(1));
        prev_s = 8'h02; prev_c = 1'b0;

        // Reset during RUN aborts with no done pulse.
        a8 = 8'hF0; b8 = 8'h0F; ci8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        chk("mrst busy", 32'(busy8), 32'(0));
        chk("mrst done", 32'(done8), 32'(0));
        chk("mrst sum", 32'(sum8), 32'(8'h00));
        chk("mrst carry", 32'(carry8), 32'(0));
        step();
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (done8) dones++;
        end
        chk("mrst no done", 32'(dones), 32'(0));
        prev_s = 8'h00; prev_c = 1'b0;
        add8(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, "post reset");

        // Back-to-back with start held: one result every WIDTH+2 cycles.
        a8 = bb[0].a; b8 = bb[0].b; ci8 = bb[0].ci; start8 = 1'b1;
        step();
        t_prev = 0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("b2b%0d busy", k), 32'(busy8), 32'(1));
            if (k < 3) begin
                a8 = bb[k+1].a; b8 = bb[k+1].b; ci8 = bb[k+1].ci;
            end else begin
                start8 = 1'b0;
            end
            repeat (8) step();
            chk($sformatf("b2b%0d done", k), 32'(done8), 32'(1));
            chk($sformatf("b2b%0d sum", k), 32'(sum8), 32'(bb[k].s));
            chk($sformatf("b2b%0d carry", k), 32'(carry8), 32'(bb[k].c));
            if (k > 0)
                chk($sformatf("b2b%0d interval", k), 32'($time - t_prev), 32'(100));
            t_prev = $time;
            step();
            chk($sformatf("b2b%0d done low", k), 32'(done8), 32'(0));
            step();
        end

        // WIDTH=1: every combination is a single full-adder evaluation.
        for (int i = 0; i < 8; i++) begin
            combo = 3'(i);
            a1 = combo[2]; b1 = combo[1]; ci1 = combo[0]; start1 = 1'b1;
            step();
            start1 = 1'b0;
            chk($sformatf("w1 %0d busy", i), 32'(busy1), 32'(1));
            step();
            chk($sformatf("w1 %0d done", i), 32'(done1), 32'(1));
            chk($sformatf("w1 %0d result", i), 32'({carry1, sum1}), 32'(exp1[i]));
            step();
            chk($sformatf("w1 %0d done low", i), 32'(done1), 32'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
